// File: rtl/aes_ahb_pkg.sv
// Shared AHB-Lite encodings, command/status codes and FSM states for the AES bus master.
package aes_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_128     = 3'b100;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_NONE    = 4'b0000;

    typedef enum logic [1:0] {
        OP_LOAD_KEY = 2'b00,
        OP_ENCRYPT  = 2'b01,
        OP_READ     = 2'b10
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_HRESP_ERR = 2'b01,
        ST_TIMEOUT   = 2'b10,
        ST_BAD_OP    = 2'b11
    } rsp_status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_ADDR,
        S_W_DATA,
        S_R_ADDR,
        S_R_DATA,
        S_ERR,
        S_RESP
    } state_t;

    // Address and data phases are the only states subject to the wait timeout.
    function automatic logic is_xfer_state(input state_t s);
        return (s == S_W_ADDR) || (s == S_W_DATA) || (s == S_R_ADDR) || (s == S_R_DATA);
    endfunction

endpackage

// File: rtl/ahb_wait_timer.sv
// Counts consecutive HREADY-low cycles of one transfer phase; flags the last permitted wait cycle.
module ahb_wait_timer #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Asserted during the TIMEOUT-th consecutive wait cycle, so the abort lands on its closing edge.
    assign o_expired = i_enable && (r_count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/aes_ahb_master.sv
// AHB-Lite initiator sequencing single 128-bit transfers to the AES slave for key-load, encrypt and read.
module aes_ahb_master
    import aes_ahb_pkg::*;
#(
    parameter logic [31:0] AES_ADDR = 32'hF0F0F0F0,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned TO_W     = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [127:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic [1:0]   rsp_status,
    output logic [31:0]  HADDR,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic [2:0]   HSIZE,
    output logic [2:0]   HBURST,
    output logic [3:0]   HPORT,
    output logic         HMASTLOCK,
    output logic         HSELx,
    output logic [127:0] HWDATA,
    input  logic         HREADY,
    input  logic         HRESP,
    input  logic [127:0] HRDATA
);

    state_t      r_state;
    state_t      w_next;
    cmd_op_t     r_op;
    logic [127:0] r_data;
    logic [127:0] r_rsp_data;
    rsp_status_t r_rsp_status;
    rsp_status_t w_status;
    logic        w_capture;
    logic        w_accept;
    logic        w_wait;
    logic        w_expired;
    logic        w_clear;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;
    assign w_wait   = is_xfer_state(r_state) && !HREADY;
    assign w_clear  = (w_next != r_state);

    ahb_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clear   (w_clear),
        .i_enable  (w_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= OP_LOAD_KEY;
            r_data       <= '0;
            r_rsp_data   <= '0;
            r_rsp_status <= ST_OK;
        end else begin
            r_state      <= w_next;
            r_rsp_status <= w_status;
            if (w_accept) begin
                r_op       <= cmd_op_t'(cmd_op);
                r_data     <= cmd_data;
                r_rsp_data <= '0;
            end else if (w_capture) begin
                r_rsp_data <= HRDATA;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_status  = r_rsp_status;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_status = ST_OK;
                    case (cmd_op)
                        OP_LOAD_KEY, OP_ENCRYPT: w_next = S_W_ADDR;
                        OP_READ:                 w_next = S_R_ADDR;
                        default: begin
                            w_next   = S_RESP;
                            w_status = ST_BAD_OP;
                        end
                    endcase
                end
            end
            S_W_ADDR, S_R_ADDR: begin
                if (HREADY) begin
                    w_next = (r_state == S_W_ADDR) ? S_W_DATA : S_R_DATA;
                end else if (w_expired) begin
                    w_next   = S_RESP;
                    w_status = ST_TIMEOUT;
                end
            end
            S_W_DATA, S_R_DATA: begin
                // Error response wins over timeout; a one-cycle error (HREADY already high) skips ERR.
                if (HRESP) begin
                    w_next   = HREADY ? S_RESP : S_ERR;
                    w_status = ST_HRESP_ERR;
                end else if (HREADY) begin
                    if (r_state == S_R_DATA) begin
                        w_next    = S_RESP;
                        w_capture = 1'b1;
                    end else begin
                        w_next = (r_op == OP_ENCRYPT) ? S_R_ADDR : S_RESP;
                    end
                end else if (w_expired) begin
                    w_next   = S_RESP;
                    w_status = ST_TIMEOUT;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign cmd_ready  = (r_state == S_IDLE) && !rst;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;

    assign HTRANS    = ((r_state == S_W_ADDR) || (r_state == S_R_ADDR)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = ((r_state == S_W_ADDR) || (r_state == S_R_ADDR)) ? AES_ADDR : '0;
    assign HWRITE    = (r_state == S_W_ADDR) || (r_state == S_W_DATA);
    assign HSELx     = is_xfer_state(r_state) || (r_state == S_ERR);
    assign HWDATA    = (r_state == S_W_DATA) ? r_data : '0;
    assign HSIZE     = HSIZE_128;
    assign HBURST    = HBURST_SINGLE;
    assign HPORT     = HPROT_NONE;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_aes_ahb_master.sv
// Directed bench for aes_ahb_master: key load, encrypt with long wait, error, bad opcode, reset, timeout.
module tb_aes_ahb_master;

    localparam logic [31:0]  ADDR = 32'hF0F0F0F0;
    localparam logic [127:0] KEY  = 128'h6c6f6c7a20676f6f64206b6579206869;
    localparam logic [127:0] PT   = 128'h656e637279707465642074657874212;
    localparam logic [127:0] CT   = {16{8'hA5}};

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]   cmd_op, rsp_status, HTRANS;
    logic [127:0] cmd_data, rsp_data, HWDATA, HRDATA;
    logic [31:0]  HADDR;
    logic         HWRITE, HMASTLOCK, HSELx, HREADY, HRESP;
    logic [2:0]   HSIZE, HBURST;
    logic [3:0]   HPORT;

    logic         t_cmd_valid, t_cmd_ready, t_rsp_valid, t_rsp_ready;
    logic [1:0]   t_rsp_status, t_HTRANS;
    logic [127:0] t_rsp_data, t_HWDATA;
    logic [31:0]  t_HADDR;
    logic         t_HWRITE, t_HMASTLOCK, t_HSELx, t_HREADY;
    logic [2:0]   t_HSIZE, t_HBURST;
    logic [3:0]   t_HPORT;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        stable;

    always #5 clk = ~clk;

    aes_ahb_master u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPORT(HPORT), .HMASTLOCK(HMASTLOCK), .HSELx(HSELx), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    aes_ahb_master #(.TIMEOUT(16)) u_dut_to (
        .clk(clk), .rst(rst),
        .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(2'b00), .cmd_data(KEY),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data), .rsp_status(t_rsp_status),
        .HADDR(t_HADDR), .HTRANS(t_HTRANS), .HWRITE(t_HWRITE), .HSIZE(t_HSIZE), .HBURST(t_HBURST),
        .HPORT(t_HPORT), .HMASTLOCK(t_HMASTLOCK), .HSELx(t_HSELx), .HWDATA(t_HWDATA),
        .HREADY(t_HREADY), .HRESP(1'b0), .HRDATA(128'h0)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; rsp_ready = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        t_cmd_valid = 1'b0; t_rsp_ready = 1'b0; t_HREADY = 1'b1;
        tick(3);
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_hsel", HSELx, 1'b0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 128'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 128'h0);
        chk("rst_rsp_status", rsp_status, 2'b00);
        chk("fixed_ctrl", {HSIZE, HBURST, HPORT, HMASTLOCK}, {3'b100, 3'b000, 4'b0000, 1'b0});
        rst = 1'b0;
        tick(1);
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // LOAD_KEY, zero-wait slave
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = KEY;
        tick(1);
        cmd_valid = 1'b0;
        chk("lk_n1_htrans", HTRANS, 2'b10);
        chk("lk_n1_ctrl", {HSELx, HWRITE, HADDR}, {1'b1, 1'b1, ADDR});
        chk("lk_n1_cmd_ready", cmd_ready, 1'b0);
        tick(1);
        chk("lk_n2_htrans", HTRANS, 2'b00);
        chk("lk_n2_hwdata", HWDATA, KEY);
        chk("lk_n2_rsp_valid", rsp_valid, 1'b0);
        tick(1);
        chk("lk_n3_rsp", {rsp_valid, rsp_status, HSELx}, {1'b1, 2'b00, 1'b0});
        chk("lk_n3_rsp_data", rsp_data, 128'h0);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk("lk_done", {rsp_valid, cmd_ready}, {1'b0, 1'b1});

        // ENCRYPT: write, then read held off by 40 HREADY-low cycles in the address phase
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = PT;
        tick(1);
        cmd_valid = 1'b0;
        chk("enc_w_addr", {HTRANS, HWRITE, HSELx}, {2'b10, 1'b1, 1'b1});
        tick(1);
        chk("enc_w_data", HWDATA, PT);
        tick(1);
        chk("enc_r_addr", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b0, ADDR});
        HREADY = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (HTRANS !== 2'b10 || HADDR !== ADDR || HWRITE !== 1'b0 || HSELx !== 1'b1 || rsp_valid !== 1'b0)
                stable = 1'b0;
            tick(1);
        end
        chk("enc_wait_stable", stable, 1'b1);
        chk("enc_still_r_addr", HTRANS, 2'b10);
        HREADY = 1'b1; HRDATA = CT;
        tick(1);
        chk("enc_r_data", {HTRANS, HSELx, rsp_valid}, {2'b00, 1'b1, 1'b0});
        tick(1);
        HRDATA = '0;
        chk("enc_rsp", {rsp_valid, rsp_status}, {1'b1, 2'b00});
        chk("enc_rsp_data", rsp_data, CT);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (rsp_valid !== 1'b1 || rsp_data !== CT || cmd_ready !== 1'b0 || HTRANS !== 2'b00)
                stable = 1'b0;
        end
        chk("rsp_hold_stable", stable, 1'b1);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk("enc_done", {rsp_valid, cmd_ready}, {1'b0, 1'b1});

        // READ with a two-cycle error response
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = '0;
        tick(1);
        cmd_valid = 1'b0;
        chk("rd_addr", {HTRANS, HWRITE}, {2'b10, 1'b0});
        tick(1);
        HRESP = 1'b1; HREADY = 1'b0;
        chk("err_first_htrans", HTRANS, 2'b00);
        tick(1);
        chk("err_state", {HTRANS, HSELx, rsp_valid}, {2'b00, 1'b1, 1'b0});
        HREADY = 1'b1;
        tick(1);
        HRESP = 1'b0;
        chk("err_status", {rsp_valid, rsp_status}, {1'b1, 2'b01});
        chk("err_rsp_data", rsp_data, 128'h0);
        rsp_ready = 1'b1;
        tick(1);
        chk("err_back_idle", cmd_ready, 1'b1);

        // Reserved opcode: immediate response, no bus activity
        cmd_valid = 1'b1; cmd_op = 2'b11;
        tick(1);
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        chk("bad_op", {rsp_valid, rsp_status, HTRANS, HSELx}, {1'b1, 2'b11, 2'b00, 1'b0});
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk("bad_op_done", cmd_ready, 1'b1);

        // Reset during the encrypt wait
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = PT;
        tick(1);
        cmd_valid = 1'b0;
        tick(2);
        HREADY = 1'b0;
        tick(5);
        chk("mid_wait_nonseq", HTRANS, 2'b10);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_bus", {HTRANS, HSELx, HWRITE, HADDR}, {2'b00, 1'b0, 1'b0, 32'h0});
        chk("mid_rst_hwdata", HWDATA, 128'h0);
        chk("mid_rst_rsp", {cmd_ready, rsp_valid, rsp_status}, {1'b0, 1'b0, 2'b00});
        rst = 1'b0; HREADY = 1'b1;
        tick(1);
        chk("post_rst_ready", {cmd_ready, HTRANS}, {1'b1, 2'b00});

        // Timeout instance (TIMEOUT=16), slave never ready
        t_cmd_valid = 1'b1; t_HREADY = 1'b0;
        tick(1);
        t_cmd_valid = 1'b0;
        chk("to_addr", {t_HTRANS, t_HSELx}, {2'b10, 1'b1});
        tick(15);
        chk("to_15_waits_busy", {t_rsp_valid, t_HSELx, t_HTRANS}, {1'b0, 1'b1, 2'b10});
        tick(1);
        chk("to_16_waits_rsp", {t_rsp_valid, t_rsp_status, t_HSELx, t_HTRANS}, {1'b1, 2'b10, 1'b0, 2'b00});
        chk("to_rsp_data", t_rsp_data, 128'h0);
        t_rsp_ready = 1'b1;
        tick(1);
        chk("to_back_idle", {t_rsp_valid, t_cmd_ready}, {1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
